// File: rtl/ex_md_unit.sv
// rtl/ex_md_unit.sv - execute stage: RV32I ALU plus M extension with iterative divide and optional iterative multiply
module ex_md_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FAST_MUL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  busy_o
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned W2  = 2 * XLEN;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nx;

  logic                  accept, is_m, start_mul, start_div, res_wreg;
  logic                  sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]       res, abs_a, abs_b;
  logic [W2-1:0]         fm_a, fm_b, fm_p;
  logic [SHW-1:0]        sh;

  logic [SHW-1:0]        cnt;
  logic [1:0]            f3_q;
  logic                  neg_q, neg_r, wreg_q, last;
  logic [REG_ADDR_W-1:0] wd_q;
  logic [W2-1:0]         mul_acc, mul_mcand, mul_sum, mul_prod;
  logic [XLEN-1:0]       mul_mplier, div_quo, div_rem, div_dvsr;
  logic [XLEN:0]         rem_sh;
  logic                  div_ge;
  logic [XLEN-1:0]       rem_nx, quo_nx, iter_res;

  // Operand sign handling shared by multiply and divide; magnitudes feed the iterative paths
  always_comb begin
    is_m = (opcode_i == OPC_OP) && (funct7_i == 7'b0000001);
    if (funct3_i[2]) begin
      sgn_a = !funct3_i[0];
      sgn_b = !funct3_i[0];
    end else begin
      sgn_a = (funct3_i[1:0] != 2'b11);
      sgn_b = !funct3_i[1];
    end
    a_neg    = sgn_a && reg1_i[XLEN-1];
    b_neg    = sgn_b && reg2_i[XLEN-1];
    abs_a    = a_neg ? -reg1_i : reg1_i;
    abs_b    = b_neg ? -reg2_i : reg2_i;
    fm_a     = {{XLEN{a_neg}}, reg1_i};
    fm_b     = {{XLEN{b_neg}}, reg2_i};
    fm_p     = fm_a * fm_b;
    sh       = reg2_i[SHW-1:0];
    div_zero = (reg2_i == '0);
    div_ovf  = !funct3_i[0] && (reg1_i == MIN_NEG) && (reg2_i == '1);
  end

  // Single-cycle result and the decision whether the op must iterate
  always_comb begin
    res       = '0;
    res_wreg  = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OP_IMM: begin
        res_wreg = 1'b1;
        if (is_m && !funct3_i[2]) begin
          if (FAST_MUL) res = (funct3_i[1:0] == 2'b00) ? fm_p[XLEN-1:0] : fm_p[W2-1:XLEN];
          else          start_mul = 1'b1;
        end else if (is_m) begin
          if (div_zero)     res = funct3_i[1] ? reg1_i : '1;
          else if (div_ovf) res = funct3_i[1] ? '0 : reg1_i;
          else              start_div = 1'b1;
        end else begin
          case (funct3_i)
            3'b000:  res = (opcode_i == OPC_OP && funct7_i[5]) ? reg1_i - reg2_i : reg1_i + reg2_i;
            3'b001:  res = reg1_i << sh;
            3'b010:  res = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            3'b011:  res = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
            3'b100:  res = reg1_i ^ reg2_i;
            3'b101:  res = funct7_i[5] ? XLEN'($signed(reg1_i) >>> sh) : reg1_i >> sh;
            3'b110:  res = reg1_i | reg2_i;
            default: res = reg1_i & reg2_i;
          endcase
        end
      end
      OPC_LUI, OPC_JAL, OPC_JALR: begin
        res      = reg2_i;
        res_wreg = 1'b1;
      end
      OPC_AUIPC, OPC_LOAD: begin
        res      = reg1_i + reg2_i;
        res_wreg = 1'b1;
      end
      default: begin
        res      = '0;
        res_wreg = 1'b0;
      end
    endcase
  end

  // One shift-add step and one restoring-divide step, plus the sign-fixed final result
  always_comb begin
    rem_sh   = {div_rem, div_quo[XLEN-1]};
    div_ge   = (rem_sh >= {1'b0, div_dvsr});
    rem_nx   = div_ge ? rem_sh[XLEN-1:0] - div_dvsr : rem_sh[XLEN-1:0];
    quo_nx   = {div_quo[XLEN-2:0], div_ge};
    mul_sum  = mul_mplier[0] ? mul_acc + mul_mcand : mul_acc;
    mul_prod = neg_q ? -mul_sum : mul_sum;
    last     = (cnt == SHW'(XLEN-1));
    if (state == S_DIV)
      iter_res = f3_q[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
    else
      iter_res = (f3_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[W2-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // FSM next state; flush always returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && start_div)      state_nx = S_DIV;
        else if (accept && start_mul) state_nx = S_MUL;
      end
      S_MUL, S_DIV: if (last) state_nx = S_DONE;
      default:      state_nx = S_IDLE;
    endcase
    if (flush_i) state_nx = S_IDLE;
  end

  // FSM outputs and the input handshake
  always_comb begin
    busy_o     = (state != S_IDLE);
    in_ready_o = (state == S_IDLE) && (!out_valid_o || out_ready_i) && !flush_i;
    accept     = in_valid_i && in_ready_o;
  end

  // Operand capture, iteration registers and the held result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      wdata_o     <= '0;
      cnt         <= '0;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      div_quo     <= '0;
      div_rem     <= '0;
      div_dvsr    <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      wreg_o      <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      if (accept) begin
        f3_q       <= funct3_i[1:0];
        neg_q      <= a_neg ^ b_neg;
        neg_r      <= a_neg;
        cnt        <= '0;
        wd_q       <= wd_i;
        wreg_q     <= wreg_i && res_wreg && (wd_i != '0);
        mul_acc    <= '0;
        mul_mcand  <= {{XLEN{1'b0}}, abs_a};
        mul_mplier <= abs_b;
        div_quo    <= abs_a;
        div_rem    <= '0;
        div_dvsr   <= abs_b;
        if (!start_mul && !start_div) begin
          out_valid_o <= 1'b1;
          wd_o        <= wd_i;
          wreg_o      <= wreg_i && res_wreg && (wd_i != '0);
          wdata_o     <= res;
        end
      end
      if (state == S_MUL || state == S_DIV) begin
        cnt        <= cnt + 1'b1;
        mul_acc    <= mul_sum;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        div_quo    <= quo_nx;
        div_rem    <= rem_nx;
        if (last) begin
          out_valid_o <= 1'b1;
          wd_o        <= wd_q;
          wreg_o      <= wreg_q;
          wdata_o     <= iter_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_md_unit.sv
// tb/tb_ex_md_unit.sv - self-checking bench for ex_md_unit, fast and iterative multiplier instances
module tb_ex_md_unit;

  typedef struct {
    int          port;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
    int          lat;
    int          acc;
    bit          seen;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        iv [2];
  logic        ordy [2];
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic [4:0]  wd;
  logic        wreg;
  logic        ir [2];
  logic        ov [2];
  logic        wro [2];
  logic        bsy [2];
  logic [4:0]  wdo [2];
  logic [31:0] wdat [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  ex_md_unit #(.XLEN(32), .REG_ADDR_W(5), .FAST_MUL(1'b1)) u_fast (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .opcode_i(op), .funct3_i(f3), .funct7_i(f7), .reg1_i(a), .reg2_i(b), .wd_i(wd), .wreg_i(wreg),
    .out_valid_o(ov[0]), .out_ready_i(ordy[0]), .wd_o(wdo[0]), .wreg_o(wro[0]), .wdata_o(wdat[0]),
    .busy_o(bsy[0]));

  ex_md_unit #(.XLEN(32), .REG_ADDR_W(5), .FAST_MUL(1'b0)) u_slow (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .opcode_i(op), .funct3_i(f3), .funct7_i(f7), .reg1_i(a), .reg2_i(b), .wd_i(wd), .wreg_i(wreg),
    .out_valid_o(ov[1]), .out_ready_i(ordy[1]), .wd_o(wdo[1]), .wreg_o(wro[1]), .wdata_o(wdat[1]),
    .busy_o(bsy[1]));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Architectural result of one instruction, straight from the ISA arithmetic
  function automatic ent_t model(input int port, input logic [6:0] o, input logic [2:0] g3,
                                 input logic [6:0] g7, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] d, input logic we);
    ent_t e;
    logic [63:0] p;
    longint lx, ly, lyu;
    int sx, sy;
    logic [31:0] r;
    logic wr;
    int lat;
    lx = $signed(x); ly = $signed(y); lyu = {32'd0, y};
    sx = $signed(x); sy = $signed(y);
    r = 32'd0; wr = 1'b0; lat = 1; p = 64'd0;
    case (o)
      7'b0110011, 7'b0010011: begin
        wr = 1'b1;
        if (o == 7'b0110011 && g7 == 7'b0000001) begin
          case (g3)
            3'd0: begin p = lx * ly; r = p[31:0]; end
            3'd1: begin p = lx * ly; r = p[63:32]; end
            3'd2: begin p = lx * lyu; r = p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
            3'd4, 3'd6: begin
              if (y == 0) r = (g3 == 3'd4) ? 32'hFFFFFFFF : x;
              else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = (g3 == 3'd4) ? x : 32'd0;
              else begin r = (g3 == 3'd4) ? sx / sy : sx % sy; lat = 33; end
            end
            default: begin
              if (y == 0) r = (g3 == 3'd5) ? 32'hFFFFFFFF : x;
              else begin r = (g3 == 3'd5) ? x / y : x % y; lat = 33; end
            end
          endcase
          if (!g3[2] && port == 1) lat = 33;
        end else begin
          case (g3)
            3'd0: r = (o == 7'b0110011 && g7[5]) ? x - y : x + y;
            3'd1: r = x << y[4:0];
            3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd3: r = (x < y) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: r = g7[5] ? 32'(sx >>> y[4:0]) : x >> y[4:0];
            3'd6: r = x | y;
            default: r = x & y;
          endcase
        end
      end
      7'b0110111, 7'b1101111, 7'b1100111: begin r = y; wr = 1'b1; end
      7'b0010111, 7'b0000011: begin r = x + y; wr = 1'b1; end
      default: begin r = 32'd0; wr = 1'b0; end
    endcase
    e.port = port; e.wd = d; e.wreg = wr && we && (d != 5'd0); e.data = r;
    e.lat = lat; e.acc = 0; e.seen = 1'b0;
    return e;
  endfunction

  // Compare process: score accepted ops, check every valid output cycle including latency
  always @(negedge clk) begin
    int idx;
    ent_t e;
    if (!rst) begin
      sb.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].port == k) idx = i;
          if (idx < 0) begin
            chk($sformatf("unexpected_out_p%0d", k), {31'd0, ov[k]}, 64'd0);
          end else begin
            e = sb[idx];
            chk($sformatf("result_p%0d", k), {26'd0, wdo[k], wro[k], wdat[k]}, {26'd0, e.wd, e.wreg, e.data});
            if (!e.seen) begin
              chk($sformatf("latency_p%0d", k), 64'(cyc - e.acc), 64'(e.lat));
              e.seen = 1'b1;
              sb[idx] = e;
            end
            if (ordy[k]) sb.delete(idx);
          end
        end
      end
      if (flush) sb.delete();
      for (int k = 0; k < 2; k++) begin
        if (iv[k] && ir[k]) begin
          e = model(k, op, f3, f7, a, b, wd, wreg);
          e.acc = cyc;
          sb.push_back(e);
        end
      end
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [6:0] o, input logic [2:0] g3, input logic [6:0] g7,
                      input logic [31:0] x, input logic [31:0] y, input logic [4:0] d, output int n);
    logic acc;
    op = o; f3 = g3; f7 = g7; a = x; b = y; wd = d; wreg = 1'b1;
    iv[k] = 1'b1;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = ir[k];
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", {63'd0, acc}, 64'd1);
    iv[k] = 1'b0;
  endtask

  task automatic pin(input string name, input int port, input logic [6:0] o, input logic [2:0] g3,
                     input logic [6:0] g7, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_d, input int exp_lat);
    ent_t e;
    e = model(port, o, g3, g7, x, y, 5'd1, 1'b1);
    chk({name, "_data"}, {32'd0, e.data}, {32'd0, exp_d});
    chk({name, "_lat"}, 64'(e.lat), 64'(exp_lat));
  endtask

  initial begin
    int n;
    iv[0] = 1'b0; iv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
    op = '0; f3 = '0; f7 = '0; a = '0; b = '0; wd = '0; wreg = 1'b0;

    // Reset values on both instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_outs_p%0d", k), {25'd0, ov[k], wdo[k], wro[k], bsy[k], wdat[k]}, 64'd0);
    end
    rst = 1'b1;
    step(1);

    // Hand-computed pins of the reference model
    pin("pin_add",    0, 7'b0110011, 3'd0, 7'h00, 32'd7, 32'hFFFFFFFD, 32'd4, 1);
    pin("pin_sub",    0, 7'b0110011, 3'd0, 7'h20, 32'd5, 32'd9, 32'hFFFFFFFC, 1);
    pin("pin_sra",    0, 7'b0110011, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'hF8000000, 1);
    pin("pin_div",    0, 7'b0110011, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    pin("pin_rem",    0, 7'b0110011, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    pin("pin_divu0",  0, 7'b0110011, 3'd5, 7'h01, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    pin("pin_removf", 0, 7'b0110011, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    pin("pin_mulh",   0, 7'b0110011, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1);
    pin("pin_mulhu",  1, 7'b0110011, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    pin("pin_mulhsu", 0, 7'b0110011, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);

    // Back-to-back single-cycle ops
    send(0, 7'b0110011, 3'd0, 7'h00, 32'd7, 32'hFFFFFFFD, 5'd1, n);
    send(0, 7'b0110011, 3'd0, 7'h20, 32'd5, 32'd9, 5'd2, n);
    send(0, 7'b0110011, 3'd5, 7'h20, 32'h80000000, 32'd4, 5'd3, n);
    chk("sra_literal", {32'd0, wdat[0]}, 64'hF8000000);

    // Remaining single-cycle opcodes and write-enable rules
    send(0, 7'b0010011, 3'd0, 7'h20, 32'd10, 32'd5, 5'd4, n);
    send(0, 7'b0110011, 3'd1, 7'h00, 32'd1, 32'd35, 5'd5, n);
    send(0, 7'b0110011, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 5'd6, n);
    send(0, 7'b0010011, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 5'd7, n);
    send(0, 7'b0010011, 3'd4, 7'h00, 32'h0000F0F0, 32'h00000FF0, 5'd8, n);
    send(0, 7'b0010011, 3'd5, 7'h00, 32'h80000000, 32'd4, 5'd9, n);
    send(0, 7'b0110011, 3'd6, 7'h00, 32'h00F0000F, 32'h0F000F00, 5'd10, n);
    send(0, 7'b0110011, 3'd7, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 5'd11, n);
    send(0, 7'b0110111, 3'd0, 7'h00, 32'd99, 32'h12345000, 5'd12, n);
    send(0, 7'b0010111, 3'd0, 7'h00, 32'h1000, 32'h20, 5'd13, n);
    send(0, 7'b1101111, 3'd0, 7'h00, 32'h1000, 32'h1004, 5'd14, n);
    send(0, 7'b0000011, 3'd2, 7'h00, 32'h2000, 32'h10, 5'd15, n);
    send(0, 7'b1100011, 3'd0, 7'h00, 32'd3, 32'd3, 5'd16, n);
    send(0, 7'b0100011, 3'd2, 7'h00, 32'd3, 32'd4, 5'd17, n);
    send(0, 7'b1111111, 3'd0, 7'h00, 32'd3, 32'd4, 5'd18, n);
    send(0, 7'b0110011, 3'd0, 7'h00, 32'd3, 32'd4, 5'd0, n);
    step(2);

    // Divide boundaries complete in one cycle
    send(0, 7'b0110011, 3'd5, 7'h01, 32'd5, 32'd0, 5'd19, n);
    send(0, 7'b0110011, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 5'd20, n);
    send(0, 7'b0110011, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 5'd21, n);
    step(2);

    // Multiply: single cycle on the fast instance, iterative on the slow one
    send(0, 7'b0110011, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 5'd22, n);
    send(0, 7'b0110011, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, n);
    step(2);
    send(1, 7'b0110011, 3'd1, 7'h01, 32'h80000000, 32'h80000000, 5'd22, n);
    step(36);
    send(1, 7'b0110011, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd23, n);
    step(36);
    send(1, 7'b0110011, 3'd0, 7'h01, 32'hFFFFFFFD, 32'd5, 5'd24, n);
    step(36);
    send(1, 7'b0110011, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25, n);
    step(36);

    // Iterative divide, stall visible on in_ready throughout
    send(0, 7'b0110011, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 5'd26, n);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if (ir[0] !== 1'b0) bad++;
      end
      chk("div_stall_cycles_ready", 64'(bad), 64'd0);
    end
    step(4);
    send(0, 7'b0110011, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2, 5'd27, n);
    step(36);
    send(0, 7'b0110011, 3'd7, 7'h01, 32'd100, 32'd7, 5'd28, n);
    step(36);

    // Back-pressure holds the result and blocks new ops
    ordy[0] = 1'b0;
    send(0, 7'b0110011, 3'd0, 7'h00, 32'd1, 32'd2, 5'd5, n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", {63'd0, ir[0]}, 64'd0);
      chk("stall_data", {32'd0, wdat[0]}, 64'd3);
    end
    step(1);
    ordy[0] = 1'b1;
    step(2);

    // Flush mid-divide discards the op; next op is accepted immediately
    send(0, 7'b0110011, 3'd4, 7'h01, 32'd100, 32'd7, 5'd9, n);
    step(5);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    send(0, 7'b0110011, 3'd0, 7'h00, 32'd20, 32'd22, 5'd10, n);
    chk("flush_next_accept_cycles", 64'(n), 64'd1);
    step(40);
    chk("pending_results", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of a divide
    send(0, 7'b0110011, 3'd4, 7'h01, 32'd1000, 32'd3, 5'd11, n);
    step(10);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_outs", {25'd0, ov[0], wdo[0], wro[0], bsy[0], wdat[0]}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", {62'd0, ir[0], bsy[0]}, 64'd2);
    step(40);
    chk("post_reset_no_output", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
